addsub_result_fifo: RTL and testbench
=====================================

# addsub_result_fifo

- Result buffer directly downstream of the combinational adder/subtractor.
- Captures each valid `{of_uf, result}` pair into a DEPTH-entry FIFO and presents it to the consumer over a valid/ready handshake.
- Maintains a saturating overflow/underflow event counter and a sticky flag for status readout.
- Decouples the single-cycle arithmetic stage from a consumer that may stall.

## Interface
Parameters:
- DATA_WIDTH, 8, width of result; matches the adder/subtractor DATA_WIDTH
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- CNT_WIDTH, 8, width of of_uf_count

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream result is valid this cycle
- in_ready  output  1  FIFO can accept; equals !full
- in_result  input  DATA_WIDTH  result from adder/subtractor
- in_of_uf  input  1  overflow/underflow flag from adder/subtractor
- out_valid  output  1  head entry valid; equals !empty
- out_ready  input  1  consumer accepts head this cycle
- out_result  output  DATA_WIDTH  head entry result
- out_of_uf  output  1  head entry flag
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- of_uf_count  output  CNT_WIDTH  number of accepted entries with of_uf=1, saturating
- of_uf_sticky  output  1  set on any accepted entry with of_uf=1
- clear_stats  input  1  synchronous clear of of_uf_count and of_uf_sticky

## Operation
Transfers:
- Push when in_valid && in_ready.
- Pop when out_valid && out_ready.
- Storage: circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping DEPTH-1 → 0. Occupancy is tracked in count.
- Head data (out_result, out_of_uf) is driven combinationally from mem[rd_ptr].

Boundary conditions:
- Full (count==DEPTH): in_ready=0; in_valid is ignored and nothing is written. No pass-through, even if a pop occurs the same cycle.
- Empty (count==0): out_valid=0. A push appears at the output the following cycle; there is no bypass.
- Simultaneous push and pop, 0<count<DEPTH: count unchanged, both pointers advance.
- in_valid without in_ready: the upstream value is dropped. The producer is responsible for holding it.
- Upstream is not required to hold data while in_ready=1.

Statistics:
- An accepted push with in_of_uf=1 sets of_uf_sticky and increments of_uf_count.
- of_uf_count saturates at 2^CNT_WIDTH-1.
- clear_stats zeroes both statistics. If clear_stats coincides with an accepted of_uf push, the result is count=1 and sticky=1; the new event is not lost.
- Statistics are independent of pops.

## Timing
- Reset (rst_n low, asynchronous): wr_ptr=rd_ptr=0, count=0, all mem entries 0, of_uf_count=0, of_uf_sticky=0.
- Resulting outputs:
  - in_ready=1
  - out_valid=0
  - out_result=0
  - out_of_uf=0
- Reset asserted mid-operation discards all entries immediately, with no wait for clk.
- Latency: push at edge N → out_valid=1 and data visible after edge N; poppable at edge N+1.
- Throughput: one push and one pop per cycle sustained when not full.
- in_ready and out_valid depend only on registered state (count). There is no combinational path from out_ready to in_ready.
- Statistics update on the same edge as the accepting push.

## Structure
- Package addsub_pkg holds:
  - DEFAULT_DATA_WIDTH=8
  - DEFAULT_FIFO_DEPTH=4
  - typedef of the entry as a packed struct {logic of_uf; logic [DATA_WIDTH-1:0] result;}. Width comes from the package constant; the module parameter must match it.
- One sub-module: sat_counter (parameter WIDTH; inputs inc, clr; clr+inc yields 1). It is instantiated for of_uf_count.

## Test plan
- Reset, then push 8'h12 (of_uf=0), 8'h34 (of_uf=1) with out_ready=0:
  - count=2, out_result=8'h12, out_of_uf=0
  - of_uf_count=1, sticky=1
- Fill 4 entries with out_ready=0, then drive in_valid with 8'hFF:
  - in_ready=0, count stays 4
  - 8'hFF never appears at the output
- Full FIFO with in_valid=1 and out_ready=1 in the same cycle:
  - pop only, count=3
  - next cycle in_ready=1 and the push is accepted
- Continuous streaming of 0x00..0x0F with out_ready=1:
  - output is in order, one value per cycle after 1-cycle latency
  - pointers wrap correctly; count never exceeds 1
- CNT_WIDTH=2, push 5 of_uf entries: of_uf_count saturates at 3.
- clear_stats together with an of_uf push: of_uf_count=1, sticky=1.
- Assert rst_n with 3 entries stored, asynchronously between edges:
  - out_valid=0, count=0, in_ready=1, of_uf_count=0 immediately

Source files
------------

// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared constants and types for the adder/subtractor result path.
//   DEFAULT_DATA_WIDTH : width of an arithmetic result
//   DEFAULT_FIFO_DEPTH : default number of buffered results
//   entry_t            : one buffered result, {of_uf, result}
// ---------------------------------------------------------------------------
package addsub_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    // of_uf sits in the MSB so a packed entry reads naturally as {flag, value}.
    typedef struct packed {
        logic                          of_uf;
        logic [DEFAULT_DATA_WIDTH-1:0] result;
    } entry_t;

endpackage

// File: rtl/addsub_result_fifo_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count one event this cycle
//   clr   : synchronous clear; clr together with inc leaves the count at 1
//   count : current value, 0 .. 2^WIDTH-1
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] r_count;

    // A clear never swallows an event arriving on the same edge, so the
    // clear branch restarts at 1 when inc is also high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= inc ? WIDTH'(1) : '0;
        end else if (inc && (r_count != MAX_VAL)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/addsub_result_fifo.sv
// ---------------------------------------------------------------------------
// addsub_result_fifo
// Buffers {of_uf, result} pairs from the combinational adder/subtractor and
// hands them to a consumer over valid/ready, while keeping overflow/underflow
// statistics.
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_valid/in_ready         : producer handshake (in_ready = !full)
//   in_result, in_of_uf       : pair to store
//   out_valid/out_ready       : consumer handshake (out_valid = !empty)
//   out_result, out_of_uf     : head entry, read combinationally
//   count                     : occupancy 0..DEPTH
//   of_uf_count, of_uf_sticky : statistics over accepted pushes
//   clear_stats               : synchronous clear of the statistics
// DATA_WIDTH must equal addsub_pkg::DEFAULT_DATA_WIDTH because the stored
// entry type is sized from the package.
// ---------------------------------------------------------------------------
module addsub_result_fifo
    import addsub_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_FIFO_DEPTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_result,
    input  logic                       in_of_uf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_result,
    output logic                       out_of_uf,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_WIDTH-1:0]       of_uf_count,
    output logic                       of_uf_sticky,
    input  logic                       clear_stats
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic               r_sticky;

    logic               w_inReady;
    logic               w_outValid;
    logic               w_push;
    logic               w_pop;
    logic               w_ofUfEvent;
    entry_t             w_head;

    // Handshake flags come only from the registered occupancy, so out_ready
    // never reaches in_ready combinationally and a full FIFO refuses a push
    // even while it is being popped.
    assign w_inReady   = (r_count != CNT_W'(DEPTH));
    assign w_outValid  = (r_count != '0);
    assign w_push      = in_valid && w_inReady;
    assign w_pop       = w_outValid && out_ready;
    assign w_ofUfEvent = w_push && in_of_uf;

    // Storage is cleared on reset so the empty FIFO presents zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wrPtr] <= '{of_uf: in_of_uf, result: in_result};
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag: a clear on the same edge as a new event keeps the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (clear_stats) begin
            r_sticky <= w_ofUfEvent;
        end else if (w_ofUfEvent) begin
            r_sticky <= 1'b1;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_ofUfCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_ofUfEvent),
        .clr   (clear_stats),
        .count (of_uf_count)
    );

    assign w_head       = r_mem[r_rdPtr];
    assign in_ready     = w_inReady;
    assign out_valid    = w_outValid;
    assign out_result   = w_head.result;
    assign out_of_uf    = w_head.of_uf;
    assign count        = r_count;
    assign of_uf_sticky = r_sticky;

endmodule

// File: tb/tb_addsub_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_addsub_result_fifo
// Directed stimulus against two instances (default counter width and a
// 2-bit counter), a queue-based reference model, a per-cycle compare
// process and hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_addsub_result_fifo;

    localparam int DW = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_result = '0;
    logic          in_of_uf = 1'b0;
    logic          out_ready = 1'b0;
    logic          clear_stats = 1'b0;

    logic          in_ready, out_valid, out_of_uf, of_uf_sticky;
    logic [DW-1:0] out_result;
    logic [2:0]    count;
    logic [7:0]    of_uf_count;

    logic          in_ready2, out_valid2, out_of_uf2, of_uf_sticky2;
    logic [DW-1:0] out_result2;
    logic [2:0]    count2;
    logic [1:0]    of_uf_count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    addsub_result_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_of_uf(in_of_uf),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_of_uf(out_of_uf),
        .count(count), .of_uf_count(of_uf_count),
        .of_uf_sticky(of_uf_sticky), .clear_stats(clear_stats)
    );

    addsub_result_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .CNT_WIDTH(2)) dutSat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_result(in_result), .in_of_uf(in_of_uf),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_result(out_result2), .out_of_uf(out_of_uf2),
        .count(count2), .of_uf_count(of_uf_count2),
        .of_uf_sticky(of_uf_sticky2), .clear_stats(clear_stats)
    );

    // One comparison: counts it and reports a mismatch on a single line.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, return just after it.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                                 input logic f, input logic r, input logic c);
        in_valid    = v;
        in_result   = d;
        in_of_uf    = f;
        out_ready   = r;
        clear_stats = c;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain queue of {of_uf, result} plus event counts,
    // following the transfer and statistics rules from the pre-edge state.
    bit [DW:0] mq[$];
    int        mCnt8;
    int        mCnt2;
    bit        mSticky;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mCnt8   = 0;
            mCnt2   = 0;
            mSticky = 0;
        end else begin
            bit doPush;
            bit doPop;
            bit ev;
            doPush = in_valid && (mq.size() < D);
            doPop  = (mq.size() > 0) && out_ready;
            ev     = doPush && in_of_uf;
            if (clear_stats) begin
                mCnt8   = ev ? 1 : 0;
                mCnt2   = ev ? 1 : 0;
                mSticky = ev;
            end else if (ev) begin
                mCnt8   = (mCnt8 < 255) ? mCnt8 + 1 : 255;
                mCnt2   = (mCnt2 < 3) ? mCnt2 + 1 : 3;
                mSticky = 1'b1;
            end
            if (doPop) void'(mq.pop_front());
            if (doPush) mq.push_back({in_of_uf, in_result});
        end
    end

    // Every falling edge out of reset, all status outputs must match the model;
    // head data is only meaningful while the model holds an entry.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("cmp_in_ready", 32'(in_ready), 32'(mq.size() < D));
            checkOutput("cmp_out_valid", 32'(out_valid), 32'(mq.size() > 0));
            checkOutput("cmp_count", 32'(count), 32'(mq.size()));
            checkOutput("cmp_of_uf_count", 32'(of_uf_count), 32'(mCnt8));
            checkOutput("cmp_of_uf_count_w2", 32'(of_uf_count2), 32'(mCnt2));
            checkOutput("cmp_sticky", 32'(of_uf_sticky), 32'(mSticky));
            if (mq.size() > 0) begin
                checkOutput("cmp_out_result", 32'(out_result), 32'(mq[0][DW-1:0]));
                checkOutput("cmp_out_of_uf", 32'(out_of_uf), 32'(mq[0][DW]));
            end
        end
    end

    initial begin
        // Reset values, sampled while reset is still held.
        #11;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_result", 32'(out_result), 32'd0);
        checkOutput("rst_out_of_uf", 32'(out_of_uf), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_of_uf_count", 32'(of_uf_count), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two pushes held by a stalled consumer.
        applyStimulus(1, 8'h12, 0, 0, 0);
        checkOutput("lat_out_valid", 32'(out_valid), 32'd1);
        checkOutput("lat_out_result", 32'(out_result), 32'h12);
        applyStimulus(1, 8'h34, 1, 0, 0);
        checkOutput("t1_count", 32'(count), 32'd2);
        checkOutput("t1_out_result", 32'(out_result), 32'h12);
        checkOutput("t1_out_of_uf", 32'(out_of_uf), 32'd0);
        checkOutput("t1_of_uf_count", 32'(of_uf_count), 32'd1);
        checkOutput("t1_sticky", 32'(of_uf_sticky), 32'd1);
        applyStimulus(0, 8'h00, 0, 1, 0);
        checkOutput("t1_pop_head", 32'(out_result), 32'h34);
        checkOutput("t1_pop_flag", 32'(out_of_uf), 32'd1);
        applyStimulus(0, 8'h00, 0, 1, 0);
        checkOutput("t1_drained", 32'(out_valid), 32'd0);

        // Fill, then offer 0xFF while full.
        for (int i = 0; i < D; i++) applyStimulus(1, 8'hA0 + 8'(i), 0, 0, 0);
        checkOutput("t2_full_count", 32'(count), 32'd4);
        checkOutput("t2_full_ready", 32'(in_ready), 32'd0);
        applyStimulus(1, 8'hFF, 0, 0, 0);
        applyStimulus(1, 8'hFF, 0, 0, 0);
        checkOutput("t2_hold_count", 32'(count), 32'd4);
        checkOutput("t2_hold_ready", 32'(in_ready), 32'd0);
        checkOutput("t2_hold_head", 32'(out_result), 32'hA0);

        // Push and pop on a full FIFO: pop only, push lands next cycle.
        applyStimulus(1, 8'h55, 0, 1, 0);
        checkOutput("t3_pop_only_count", 32'(count), 32'd3);
        checkOutput("t3_ready_back", 32'(in_ready), 32'd1);
        checkOutput("t3_head", 32'(out_result), 32'hA1);
        applyStimulus(1, 8'h55, 0, 1, 0);
        checkOutput("t3_both_count", 32'(count), 32'd3);
        checkOutput("t3_both_head", 32'(out_result), 32'hA2);
        applyStimulus(0, 8'h00, 0, 1, 0);
        checkOutput("t3_drain_a3", 32'(out_result), 32'hA3);
        applyStimulus(0, 8'h00, 0, 1, 0);
        checkOutput("t3_drain_55", 32'(out_result), 32'h55);
        applyStimulus(0, 8'h00, 0, 1, 0);
        checkOutput("t3_empty", 32'(out_valid), 32'd0);

        // Streaming 0x00..0x0F with the consumer always ready.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 8'(i), 0, 1, 0);
            checkOutput("t4_stream_count", 32'(count), 32'd1);
            checkOutput("t4_stream_data", 32'(out_result), 32'(i));
        end
        applyStimulus(0, 8'h00, 0, 1, 0);
        checkOutput("t4_stream_empty", 32'(out_valid), 32'd0);

        // Clear, then five events: the 2-bit counter saturates at 3.
        applyStimulus(0, 8'h00, 0, 1, 1);
        checkOutput("t5_clr_count", 32'(of_uf_count), 32'd0);
        checkOutput("t5_clr_sticky", 32'(of_uf_sticky), 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'h80 + 8'(i), 1, 1, 0);
        checkOutput("t5_count8", 32'(of_uf_count), 32'd5);
        checkOutput("t5_count2_sat", 32'(of_uf_count2), 32'd3);
        checkOutput("t5_sticky", 32'(of_uf_sticky2), 32'd1);
        applyStimulus(0, 8'h00, 0, 1, 0);

        // Clear coinciding with an event keeps the event.
        applyStimulus(1, 8'h77, 1, 1, 1);
        checkOutput("t6_count8", 32'(of_uf_count), 32'd1);
        checkOutput("t6_count2", 32'(of_uf_count2), 32'd1);
        checkOutput("t6_sticky", 32'(of_uf_sticky), 32'd1);
        applyStimulus(0, 8'h00, 0, 1, 0);

        // Asynchronous reset between edges with three entries stored.
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'h40 + 8'(i), 0, 0, 0);
        checkOutput("t7_pre_count", 32'(count), 32'd3);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t7_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t7_count", 32'(count), 32'd0);
        checkOutput("t7_in_ready", 32'(in_ready), 32'd1);
        checkOutput("t7_of_uf_count", 32'(of_uf_count), 32'd0);
        checkOutput("t7_out_result", 32'(out_result), 32'd0);
        #3 rst_n = 1'b1;
        applyStimulus(1, 8'h99, 0, 0, 0);
        checkOutput("t7_after_count", 32'(count), 32'd1);
        checkOutput("t7_after_head", 32'(out_result), 32'h99);
        applyStimulus(0, 8'h00, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
